// File: rtl/regfile_param_init_if.sv
// Bus bundle for regfile_param_init: read/write addresses, write data and status.
// The master drives addresses and writes; the slave (register file) returns data and status.
interface regfile_param_init_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] Data_In;
   logic              RegWrite;
   logic [DATA_W-1:0] Rdata1;
   logic [DATA_W-1:0] Rdata2;
   logic              busy;
   logic              wr_drop;

   modport master (
      output rs, rt, rd, Data_In, RegWrite,
      input  Rdata1, Rdata2, busy, wr_drop
   );

   modport slave (
      input  rs, rt, rd, Data_In, RegWrite,
      output Rdata1, Rdata2, busy, wr_drop
   );
endinterface

// File: rtl/regfile_param_init.sv
// 2-read/1-write register file with a reset-triggered clear sequencer (one entry per cycle).
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding onto the read ports.
module regfile_param_init #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int INIT_MODE = 1,
   parameter int ZERO_REG  = 0
) (
   input logic                 clk,
   input logic                 rst,
   regfile_param_init_if.slave bus
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] CNT_STEP = (ADDR_W + 1)'(1);

   typedef enum logic {
      CLEAR,
      READY
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wr_drop_q, wr_drop_d;
   logic              busy;
   logic              zero_hit;
   logic              write_ok;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem [DEPTH];

   assign busy     = (state_q == CLEAR);
   assign zero_hit = (ZERO_REG != 0) && (bus.rd == '0);
   assign write_ok = !busy && bus.RegWrite && !zero_hit;

   // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_addr  = bus.rd;
      mem_wdata = bus.Data_In;
      wr_drop_d = bus.RegWrite && (busy || zero_hit);

      case (state_q)
         CLEAR: begin
            // The clear engine owns the write port; user writes are dropped.
            mem_we    = 1'b1;
            mem_addr  = cnt_q[ADDR_W-1:0];
            mem_wdata = (INIT_MODE != 0) ? DATA_W'(cnt_q[ADDR_W-1:0]) : '0;
            cnt_d     = cnt_q + CNT_STEP;
            if (cnt_q == CNT_LAST) begin
               state_d = READY;
            end
         end
         READY: begin
            mem_we = write_ok;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // NOTE: the array has no reset branch; the clear sequence initialises it after rst.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_comb begin
      bus.Rdata1 = mem[bus.rs];
`ifdef REGFILE_BYPASS_EN
      if (write_ok && (bus.rd == bus.rs)) begin
         bus.Rdata1 = bus.Data_In;
      end
`endif
      if (busy || ((ZERO_REG != 0) && (bus.rs == '0))) begin
         bus.Rdata1 = '0;
      end
   end

   always_comb begin
      bus.Rdata2 = mem[bus.rt];
`ifdef REGFILE_BYPASS_EN
      if (write_ok && (bus.rd == bus.rt)) begin
         bus.Rdata2 = bus.Data_In;
      end
`endif
      if (busy || ((ZERO_REG != 0) && (bus.rt == '0))) begin
         bus.Rdata2 = '0;
      end
   end

   assign bus.busy    = busy;
   assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_param_init.sv
// Directed bench for regfile_param_init: a default instance and a small ZERO_REG/zero-init instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_regfile_param_init;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   regfile_param_init_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
   regfile_param_init_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();

   regfile_param_init #(
      .DATA_W(32), .ADDR_W(5), .INIT_MODE(1), .ZERO_REG(0)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(bus0)
   );

   regfile_param_init #(
      .DATA_W(16), .ADDR_W(3), .INIT_MODE(0), .ZERO_REG(1)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts falling edges until dut0 leaves CLEAR; a timeout counts as an error.
   task automatic wait_ready0(input int exp_cycles, input string tag);
      int n;
      n = 0;
      while (bus0.busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== exp_cycles) begin
         errors++;
         $display("FAIL %s_clear_len: got %0d cycles expected %0d", tag, n, exp_cycles);
      end
   endtask

   task automatic test_reset();
      logic e0, e1;
      rst = 1'b1;
      bus0.rs = 5'd7; bus0.rt = 5'd31; bus0.rd = '0; bus0.Data_In = '0; bus0.RegWrite = 1'b0;
      bus1.rs = 3'd5; bus1.rt = 3'd7; bus1.rd = '0; bus1.Data_In = '0; bus1.RegWrite = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus0.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus0.busy); end
      checks++;
      if (bus0.wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b expected 0", bus0.wr_drop); end
      checks++;
      if (bus0.Rdata1 !== 32'd0) begin errors++; $display("FAIL reset_rdata1: got %0h expected 0", bus0.Rdata1); end
      checks++;
      if (bus1.busy !== 1'b1) begin errors++; $display("FAIL reset_busy_z: got %b expected 1", bus1.busy); end
      rst = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         e0 = (k < 32);
         e1 = (k < 8);
         checks++;
         if (bus0.busy !== e0) begin errors++; $display("FAIL clear_busy k=%0d: got %b expected %b", k, bus0.busy, e0); end
         checks++;
         if (bus1.busy !== e1) begin errors++; $display("FAIL clear_busy_z k=%0d: got %b expected %b", k, bus1.busy, e1); end
         if (e0) begin
            checks++;
            if (bus0.Rdata1 !== 32'd0) begin errors++; $display("FAIL busy_read k=%0d: got %0h expected 0", k, bus0.Rdata1); end
         end
      end
      #1;
      checks++;
      if (bus0.Rdata1 !== 32'd7) begin errors++; $display("FAIL init_rs7: got %0h expected 7", bus0.Rdata1); end
      checks++;
      if (bus0.Rdata2 !== 32'd31) begin errors++; $display("FAIL init_rt31: got %0h expected 1f", bus0.Rdata2); end
      checks++;
      if (bus1.Rdata1 !== 16'd0 || bus1.Rdata2 !== 16'd0) begin
         errors++; $display("FAIL init_zero_mode: got %0h/%0h expected 0/0", bus1.Rdata1, bus1.Rdata2);
      end
   endtask

   task automatic test_write();
      @(negedge clk);
      bus0.RegWrite = 1'b1; bus0.rd = 5'd3; bus0.Data_In = 32'hDEADBEEF; bus0.rs = 5'd3; bus0.rt = 5'd4;
      @(negedge clk);
      bus0.RegWrite = 1'b1; bus0.rd = 5'd0; bus0.Data_In = 32'h77;
      #1;
      checks++;
      if (bus0.Rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rs3: got %0h expected deadbeef", bus0.Rdata1); end
      checks++;
      if (bus0.Rdata2 !== 32'd4) begin errors++; $display("FAIL write_rt4: got %0h expected 4", bus0.Rdata2); end
      checks++;
      if (bus0.wr_drop !== 1'b0) begin errors++; $display("FAIL write_no_drop: got %b expected 0", bus0.wr_drop); end
      @(negedge clk);
      bus0.RegWrite = 1'b0; bus0.rs = 5'd0;
      #1;
      checks++;
      if (bus0.Rdata1 !== 32'h77) begin errors++; $display("FAIL write_entry0: got %0h expected 77", bus0.Rdata1); end
      checks++;
      if (bus0.wr_drop !== 1'b0) begin errors++; $display("FAIL write0_no_drop: got %b expected 0", bus0.wr_drop); end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      bus1.RegWrite = 1'b1; bus1.rd = 3'd0; bus1.Data_In = 16'h55; bus1.rs = 3'd0;
      @(negedge clk);
      bus1.RegWrite = 1'b1; bus1.rd = 3'd2; bus1.Data_In = 16'hAB;
      #1;
      checks++;
      if (bus1.wr_drop !== 1'b1) begin errors++; $display("FAIL zero_drop: got %b expected 1", bus1.wr_drop); end
      checks++;
      if (bus1.Rdata1 !== 16'd0) begin errors++; $display("FAIL zero_read: got %0h expected 0", bus1.Rdata1); end
      @(negedge clk);
      bus1.RegWrite = 1'b0; bus1.rs = 3'd2; bus1.rt = 3'd3;
      #1;
      checks++;
      if (bus1.wr_drop !== 1'b0) begin errors++; $display("FAIL zero_normal_drop: got %b expected 0", bus1.wr_drop); end
      checks++;
      if (bus1.Rdata1 !== 16'hAB) begin errors++; $display("FAIL zero_normal_write: got %0h expected ab", bus1.Rdata1); end
      checks++;
      if (bus1.Rdata2 !== 16'd0) begin errors++; $display("FAIL zero_untouched: got %0h expected 0", bus1.Rdata2); end
   endtask

   task automatic test_bypass();
      logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'h1234;
`else
      exp_same = 32'd9;
`endif
      @(negedge clk);
      bus0.RegWrite = 1'b1; bus0.rd = 5'd9; bus0.rs = 5'd9; bus0.rt = 5'd9; bus0.Data_In = 32'h1234;
      bus1.RegWrite = 1'b1; bus1.rd = 3'd0; bus1.rs = 3'd0; bus1.rt = 3'd0; bus1.Data_In = 16'h99;
      #1;
      checks++;
      if (bus0.Rdata1 !== exp_same || bus0.Rdata2 !== exp_same) begin
         errors++; $display("FAIL bypass_same_cycle: got %0h/%0h expected %0h", bus0.Rdata1, bus0.Rdata2, exp_same);
      end
      checks++;
      if (bus1.Rdata1 !== 16'd0 || bus1.Rdata2 !== 16'd0) begin
         errors++; $display("FAIL bypass_zero_override: got %0h/%0h expected 0/0", bus1.Rdata1, bus1.Rdata2);
      end
      @(negedge clk);
      bus0.RegWrite = 1'b0; bus1.RegWrite = 1'b0;
      #1;
      checks++;
      if (bus0.Rdata1 !== 32'h1234 || bus0.Rdata2 !== 32'h1234) begin
         errors++; $display("FAIL bypass_next_cycle: got %0h/%0h expected 1234", bus0.Rdata1, bus0.Rdata2);
      end
      checks++;
      if (bus1.wr_drop !== 1'b1) begin errors++; $display("FAIL bypass_zero_drop: got %b expected 1", bus1.wr_drop); end
   endtask

   task automatic test_clear_drop();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      bus0.RegWrite = 1'b1; bus0.rd = 5'd20; bus0.Data_In = 32'hFFFFFFFF;
      @(negedge clk);
      bus0.RegWrite = 1'b0;
      checks++;
      if (bus0.wr_drop !== 1'b1) begin errors++; $display("FAIL clear_drop_pulse: got %b expected 1", bus0.wr_drop); end
      @(negedge clk);
      checks++;
      if (bus0.wr_drop !== 1'b0) begin errors++; $display("FAIL clear_drop_end: got %b expected 0", bus0.wr_drop); end
      wait_ready0(25, "clear_drop");
      bus0.rs = 5'd20; bus0.rt = 5'd3;
      #1;
      checks++;
      if (bus0.Rdata1 !== 32'd20) begin errors++; $display("FAIL clear_drop_rd: got %0h expected 14", bus0.Rdata1); end
      checks++;
      if (bus0.Rdata2 !== 32'd3) begin errors++; $display("FAIL clear_reinit3: got %0h expected 3", bus0.Rdata2); end
   endtask

   task automatic test_reset_restart();
      @(negedge clk);
      bus0.RegWrite = 1'b1; bus0.rd = 5'd12; bus0.Data_In = 32'hCAFE; bus0.rs = 5'd12;
      @(negedge clk);
      bus0.RegWrite = 1'b0;
      #1;
      checks++;
      if (bus0.Rdata1 !== 32'hCAFE) begin errors++; $display("FAIL restart_prewrite: got %0h expected cafe", bus0.Rdata1); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus0.busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b expected 1", bus0.busy); end
      rst = 1'b0;
      wait_ready0(32, "restart");
      bus0.rs = 5'd12; bus0.rt = 5'd0;
      #1;
      checks++;
      if (bus0.Rdata1 !== 32'd12) begin errors++; $display("FAIL restart_entry12: got %0h expected c", bus0.Rdata1); end
      checks++;
      if (bus0.Rdata2 !== 32'd0) begin errors++; $display("FAIL restart_entry0: got %0h expected 0", bus0.Rdata2); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_zero_reg();
      test_bypass();
      test_clear_drop();
      test_reset_restart();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
